stream_fdct_1d: RTL
===================

Name: stream_fdct_1d

Overview:
- Forward 8-point 1D DCT on a NASTI stream. This is the encoder-side counterpart of the team's streaming 1D IDCT stage.
- Each input beat carries one row of 8 signed samples. Each output beat carries 8 signed DCT coefficients in orthonormal scaling (X[k] = c(k)/2 · Σ x[n]·cos((2n+1)kπ/16), with c(0) = 1/√2 and c(k>0) = 1).
- Two instances plus a transpose buffer form the 2D FDCT in the video encoder path.

Parameters:
- COEF_WIDTH, 16, width of each signed input sample and each output coefficient.
- ACC_WIDTH (localparam), COEF_WIDTH+12, internal signed datapath width. It covers the worst-case odd sum of 4·512·2^(COEF_WIDTH).

Ports:
- aclk  input  1  clock; all state updates on the rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- in_ch  nasti_stream_channel.slave  t_data 8*COEF_WIDTH  input row. Lane i = t_data[i*COEF_WIDTH +: COEF_WIDTH] = x[i]. t_last is carried through.
- out_ch  nasti_stream_channel.master  t_data 8*COEF_WIDTH  output row. Lane k = X[k]. t_strb='1, t_keep='1, t_dest='0.

Behaviour:
- Reset (async, active-low): all 5 stage-valid flags clear. out_ch.t_valid=0, out_ch.t_last=0, out_ch.t_data=0.
  - Reset mid-operation drops all in-flight beats. No partial beat is emitted after reset release.
- Pipeline: 5 registered stages with a valid flag per stage (v1..v5). v5 drives out_ch.t_valid.
- Handshake:
  - Stage k advances when v[k-1]=1 and (v[k]=0 or stage k advances this cycle).
  - Stage 5 drains when out_ch.t_valid && t_ready.
  - in_ch.t_ready = !v1 || stage 2 advances. This is combinational from downstream, with no registered skid.
  - Full throughput is 1 beat/cycle. Under sustained backpressure the block holds exactly 5 beats. No data is lost or duplicated.
  - out_ch.t_data and t_last stay stable while t_valid=1 and t_ready=0.
- Latency: a beat accepted on edge N presents t_valid on edge N+5 when no backpressure is applied.
- Stage datapaths:
  - S1: s[i]=x[i]+x[7-i]; d[i]=x[i]-x[7-i], for i=0..3.
  - S2: e0=s0+s3, e1=s1+s2, e2=s0-s3, e3=s1-s2. d0..d3 pass through.
  - S3: products with Q10 constants C4=362, C2=473, C6=196, C1=502, C3=426, C5=284, C7=100.
  - S4: sums.
    - P0=C4(e0+e1), P4=C4(e0-e1)
    - P2=C2e2+C6e3, P6=C6e2-C2e3
    - P1=C1d0+C3d1+C5d2+C7d3
    - P3=C3d0-C7d1-C1d2-C5d3
    - P5=C5d0-C1d1+C7d2+C3d3
    - P7=C7d0-C5d1+C3d2-C1d3
  - S5: X[k] = P[k]/1024, rounded half away from zero, i.e. sign(P)·((|P|+512)>>10). Then saturate to signed COEF_WIDTH, or wrap per the optional feature. Rounding is symmetric: negating all inputs negates all outputs exactly.
- t_last travels with its beat through all stages. No framing checks are performed.
- Simultaneous accept and drain in the same cycle is legal at every stage.

Optional Feature:
- Macro: STREAM_FDCT_SAT_EN.
- Defined: S5 clamps X[k] to [-2^(COEF_WIDTH-1), 2^(COEF_WIDTH-1)-1].
- Undefined: S5 keeps the low COEF_WIDTH bits of the rounded value (two's-complement wrap) and saves the comparators.
- Handshake and latency are identical in both builds.

Decomposition:
- Package stream_dct_pkg holds:
  - Q10 constants C1..C7 and COEF_FRAC=10.
  - Function round_q10 (half away from zero).
  - These are shared with a future rewrite of the IDCT.
- One sub-module, dct_round_sat: combinational round + saturate/wrap for one lane, instantiated 8× in S5. It takes the STREAM_FDCT_SAT_EN selection.

Test Plan:
- DC row, all x=64 → X=[181,0,0,0,0,0,0,0]. First output t_valid exactly 5 cycles after accept.
- Impulse x=[64,0,0,0,0,0,0,0] → X=[23,31,30,27,23,18,12,6]. Impulse x0=-64 → all values exactly negated.
- Overflow, all x=32767 → X0=32767 with STREAM_FDCT_SAT_EN; X0=27133 without it. X1..X7=0 in both builds.
- Throughput and backpressure:
  - 16 back-to-back beats with t_ready held high → 16 outputs on consecutive cycles.
  - Then t_ready=0 for 10 cycles → in_ch.t_ready falls after 5 further accepts. Output data and t_last stay stable. Order is preserved on release.
- t_last: last asserted on beats 8 and 16 of a random stream → out t_last on exactly output beats 8 and 16.
- Reset mid-stream: assert aresetn=0 with 3 beats in flight → out t_valid=0 immediately (asynchronously). After release, the next input yields the first output, with no stale beats.

Source files
------------

// File: rtl/stream_dct_pkg.sv
// Shared 8-point DCT constants and rounding helper (Q10 fixed point).
package stream_dct_pkg;

    localparam int COEF_FRAC = 10;

    // cos(k*pi/16)/2 in Q10; C4 doubles as the DC scale 1/(2*sqrt(2))
    localparam int C1 = 502;
    localparam int C2 = 473;
    localparam int C3 = 426;
    localparam int C4 = 362;
    localparam int C5 = 284;
    localparam int C6 = 196;
    localparam int C7 = 100;

    // Fixed working width for the rounding helper; callers sign-extend into it
    localparam int RND_W = 48;

    // Divide by 2^COEF_FRAC, rounding half away from zero (symmetric in sign)
    function automatic logic signed [RND_W-1:0] round_q10(input logic signed [RND_W-1:0] p);
        logic signed [RND_W-1:0] mag;
        logic signed [RND_W-1:0] q;
        mag = p[RND_W-1] ? -p : p;
        q   = (mag + RND_W'(1 << (COEF_FRAC - 1))) >>> COEF_FRAC;
        return p[RND_W-1] ? -q : q;
    endfunction

endpackage

// File: rtl/nasti_stream_channel.sv
// NASTI stream channel bundle with master/slave views.
interface nasti_stream_channel #(
    parameter int DATA_W = 128,
    parameter int DEST_W = 4
);
    logic              t_valid;
    logic              t_ready;
    logic [DATA_W-1:0] t_data;
    logic [DATA_W/8-1:0] t_strb;
    logic [DATA_W/8-1:0] t_keep;
    logic              t_last;
    logic [DEST_W-1:0] t_dest;

    modport master (output t_valid, t_data, t_strb, t_keep, t_last, t_dest, input t_ready);
    modport slave  (input t_valid, t_data, t_strb, t_keep, t_last, t_dest, output t_ready);
endinterface

// File: rtl/dct_round_sat.sv
// One output lane: Q10 -> integer with symmetric rounding, then clamp or wrap.
// STREAM_FDCT_SAT_EN defined: clamp to the signed COEF_WIDTH range.
// STREAM_FDCT_SAT_EN undefined: keep the low COEF_WIDTH bits (two's-complement wrap).
module dct_round_sat
    import stream_dct_pkg::*;
#(
    parameter int ACC_WIDTH  = 28,
    parameter int COEF_WIDTH = 16
) (
    input  logic signed [ACC_WIDTH-1:0]  p,
    output logic signed [COEF_WIDTH-1:0] x
);

    logic signed [RND_W-1:0] r;

    assign r = round_q10(RND_W'(p));

`ifdef STREAM_FDCT_SAT_EN
    localparam longint X_MAX_L = (longint'(1) << (COEF_WIDTH - 1)) - 1;
    localparam logic signed [RND_W-1:0] X_MAX = RND_W'(X_MAX_L);
    localparam logic signed [RND_W-1:0] X_MIN = ~X_MAX;

    // Clamp the rounded value into the output range
    always_comb begin
        x = r[COEF_WIDTH-1:0];
        if (r > X_MAX)      x = X_MAX[COEF_WIDTH-1:0];
        else if (r < X_MIN) x = X_MIN[COEF_WIDTH-1:0];
    end
`else
    // Upper bits are intentionally discarded in the wrapping build
    logic unused_hi;
    assign unused_hi = ^r[RND_W-1:COEF_WIDTH];
    assign x = r[COEF_WIDTH-1:0];
`endif

endmodule

// File: rtl/stream_fdct_1d.sv
// Streaming 8-point forward DCT, one row per beat, 5 elastic stages.
// Output saturation vs wrap is chosen by STREAM_FDCT_SAT_EN (see dct_round_sat).
module stream_fdct_1d
    import stream_dct_pkg::*;
#(
    parameter int COEF_WIDTH = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    nasti_stream_channel.slave  in_ch,
    nasti_stream_channel.master out_ch
);

    localparam int ACC_WIDTH = COEF_WIDTH + 12;
    localparam int STAGES    = 5;
    localparam int LANES     = 8;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    localparam acc_t K2 = acc_t'(C2);
    localparam acc_t K4 = acc_t'(C4);
    localparam acc_t K6 = acc_t'(C6);
    // odd-row constants, indexed 0..3 = C1, C3, C5, C7
    localparam acc_t KO [4] = '{acc_t'(C1), acc_t'(C3), acc_t'(C5), acc_t'(C7)};

    // ---------------- handshake ----------------
    logic [STAGES:1]   vld_q;
    logic [STAGES:1]   last_q;
    logic [STAGES:0]   vld_pipe;   // [0] is upstream valid
    logic [STAGES:0]   last_pipe;
    logic [STAGES+1:1] rdy;        // stage k free now or freed this cycle
    logic [STAGES:1]   adv;        // stage k loads this cycle

    assign vld_pipe  = {vld_q, in_ch.t_valid};
    assign last_pipe = {last_q, in_ch.t_last};

    // Ready ripples back from the sink; a full stage is ready only if it drains
    always_comb begin
        rdy = '0;
        rdy[STAGES+1] = out_ch.t_ready;
        for (int k = STAGES; k >= 1; k--) rdy[k] = !vld_pipe[k] || rdy[k+1];
    end

    // A stage loads when its predecessor holds a beat and it can take it
    always_comb begin
        adv = '0;
        for (int k = 1; k <= STAGES; k++) adv[k] = vld_pipe[k-1] && rdy[k];
    end

    // Stage valid flags and t_last travel together
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (adv[k]) begin
                    vld_q[k]  <= 1'b1;
                    last_q[k] <= last_pipe[k-1];
                end else if (rdy[k+1]) begin
                    vld_q[k]  <= 1'b0;
                end
            end
        end
    end

    // ---------------- datapath ----------------
    acc_t x_in [LANES];
    acc_t s1_s [4];
    acc_t s1_d [4];
    acc_t s2_e [4];
    acc_t s2_d [4];
    acc_t s3_pe [6];      // C4e0, C4e1, C2e2, C6e2, C2e3, C6e3
    acc_t s3_pd [4][4];   // d[i] * {C1,C3,C5,C7}[j]
    acc_t s4_p [LANES];
    logic [LANES-1:0][COEF_WIDTH-1:0] out_data;
    logic signed [COEF_WIDTH-1:0] x_rnd [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_in
        assign x_in[i] = acc_t'($signed(in_ch.t_data[i*COEF_WIDTH +: COEF_WIDTH]));
    end

    // S1: mirror butterfly
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_s <= '{default: '0};
            s1_d <= '{default: '0};
        end else if (adv[1]) begin
            for (int i = 0; i < 4; i++) begin
                s1_s[i] <= x_in[i] + x_in[7-i];
                s1_d[i] <= x_in[i] - x_in[7-i];
            end
        end
    end

    // S2: even-half butterfly, odd half passes through
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s2_e <= '{default: '0};
            s2_d <= '{default: '0};
        end else if (adv[2]) begin
            s2_e[0] <= s1_s[0] + s1_s[3];
            s2_e[1] <= s1_s[1] + s1_s[2];
            s2_e[2] <= s1_s[0] - s1_s[3];
            s2_e[3] <= s1_s[1] - s1_s[2];
            s2_d    <= s1_d;
        end
    end

    // S3: constant multiplies
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s3_pe <= '{default: '0};
            s3_pd <= '{default: '{default: '0}};
        end else if (adv[3]) begin
            s3_pe[0] <= K4 * s2_e[0];
            s3_pe[1] <= K4 * s2_e[1];
            s3_pe[2] <= K2 * s2_e[2];
            s3_pe[3] <= K6 * s2_e[2];
            s3_pe[4] <= K2 * s2_e[3];
            s3_pe[5] <= K6 * s2_e[3];
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    s3_pd[i][j] <= s2_d[i] * KO[j];
        end
    end

    // S4: combine products into the eight Q10 coefficients
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s4_p <= '{default: '0};
        end else if (adv[4]) begin
            s4_p[0] <= s3_pe[0] + s3_pe[1];
            s4_p[4] <= s3_pe[0] - s3_pe[1];
            s4_p[2] <= s3_pe[2] + s3_pe[5];
            s4_p[6] <= s3_pe[3] - s3_pe[4];
            s4_p[1] <= s3_pd[0][0] + s3_pd[1][1] + s3_pd[2][2] + s3_pd[3][3];
            s4_p[3] <= s3_pd[0][1] - s3_pd[1][3] - s3_pd[2][0] - s3_pd[3][2];
            s4_p[5] <= s3_pd[0][2] - s3_pd[1][0] + s3_pd[2][3] + s3_pd[3][1];
            s4_p[7] <= s3_pd[0][3] - s3_pd[1][2] + s3_pd[2][1] - s3_pd[3][0];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_rs
        dct_round_sat #(.ACC_WIDTH(ACC_WIDTH), .COEF_WIDTH(COEF_WIDTH)) u_rs (
            .p (s4_p[k]),
            .x (x_rnd[k])
        );
    end

    // S5: register rounded lanes; held while the sink stalls
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data <= '0;
        end else if (adv[5]) begin
            for (int k = 0; k < LANES; k++) out_data[k] <= x_rnd[k];
        end
    end

    assign in_ch.t_ready  = rdy[1];
    assign out_ch.t_valid = vld_q[STAGES];
    assign out_ch.t_last  = last_q[STAGES];
    assign out_ch.t_data  = out_data;
    assign out_ch.t_strb  = '1;
    assign out_ch.t_keep  = '1;
    assign out_ch.t_dest  = '0;

    // Sideband on the input carries nothing this block needs
    logic unused_in;
    assign unused_in = ^{in_ch.t_strb, in_ch.t_keep, in_ch.t_dest};

endmodule
